// File: rtl/ts_capture_arbiter_if.sv
// Bundle between the capture arbiter, its requesting detectors and the shared PPS timestamp unit.
// The slave modport is the arbiter; the master modport drives requests and models the unit.
`timescale 1ns/1ps
interface ts_capture_arbiter_if #(
  parameter int NUM_CH                  = 4,
  parameter int UTC_SECONDS_WIDTH       = 6,
  parameter int COUNT_LAST_SECOND_WIDTH = 26,
  parameter int DRIFT_COUNT_WIDTH       = 13,
  parameter int WAIT_WIDTH              = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]                   req;
  logic                                ts_event;
  logic                                ts_confirm;
  logic [UTC_SECONDS_WIDTH-1:0]        ts_utc;
  logic [COUNT_LAST_SECOND_WIDTH-1:0]  ts_clk;
  logic signed [DRIFT_COUNT_WIDTH-1:0] ts_drift;
  logic                                ts_ready;
  logic                                rsp_valid;
  logic [CH_W-1:0]                     rsp_ch;
  logic [UTC_SECONDS_WIDTH-1:0]        rsp_utc;
  logic [COUNT_LAST_SECOND_WIDTH-1:0]  rsp_clk;
  logic signed [DRIFT_COUNT_WIDTH-1:0] rsp_drift;
  logic [WAIT_WIDTH-1:0]               rsp_wait;
  logic                                rsp_err;
  logic [NUM_CH-1:0]                   overrun;
  logic                                busy;

  modport master (
    output req, ts_utc, ts_clk, ts_drift, ts_ready,
    input  ts_event, ts_confirm, rsp_valid, rsp_ch, rsp_utc, rsp_clk, rsp_drift,
    input  rsp_wait, rsp_err, overrun, busy
  );

  modport slave (
    input  req, ts_utc, ts_clk, ts_drift, ts_ready,
    output ts_event, ts_confirm, rsp_valid, rsp_ch, rsp_utc, rsp_clk, rsp_drift,
    output rsp_wait, rsp_err, overrun, busy
  );
endinterface

// File: rtl/ts_capture_arbiter.sv
// Round-robin sharing of one PPS timestamp unit among NUM_CH detectors: latches requests,
// runs the event/confirm/ready handshake per grant and returns the result plus wait time.
`timescale 1ns/1ps
module ts_capture_arbiter #(
  parameter int NUM_CH                  = 4,
  parameter int UTC_SECONDS_WIDTH       = 6,
  parameter int COUNT_LAST_SECOND_WIDTH = 26,
  parameter int DRIFT_COUNT_WIDTH       = 13,
  parameter int WAIT_WIDTH              = 8,
  parameter int CONFIRM_DELAY           = 2,
  parameter int READY_TIMEOUT           = 15
) (
  input  logic                clk,
  input  logic                rst,
  ts_capture_arbiter_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GAP_W = $clog2(CONFIRM_DELAY + 1);
  localparam int TO_W  = $clog2(READY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EVENT   = 3'd1,
    S_GAP     = 3'd2,
    S_CONFIRM = 3'd3,
    S_WAITR   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                              r_state;
  state_t                              w_state_next;
  logic [NUM_CH-1:0]                   r_pending;
  logic [WAIT_WIDTH-1:0]               r_wait_cnt [NUM_CH];
  logic [CH_W-1:0]                     r_ptr;
  logic [CH_W-1:0]                     r_grant_ch;
  logic [WAIT_WIDTH-1:0]               r_grant_wait;
  logic [GAP_W-1:0]                    r_gap_cnt;
  logic [TO_W-1:0]                     r_to_cnt;
  logic                                w_grant_vld;
  logic [CH_W-1:0]                     w_grant_ch;
  logic [CH_W-1:0]                     w_cand;
  logic [NUM_CH-1:0]                   w_grant_oh;
  logic                                w_timeout;
  logic                                r_ts_event;
  logic                                r_ts_confirm;
  logic                                r_rsp_valid;
  logic                                r_busy;
  logic [CH_W-1:0]                     r_rsp_ch;
  logic [UTC_SECONDS_WIDTH-1:0]        r_rsp_utc;
  logic [COUNT_LAST_SECOND_WIDTH-1:0]  r_rsp_clk;
  logic signed [DRIFT_COUNT_WIDTH-1:0] r_rsp_drift;
  logic [WAIT_WIDTH-1:0]               r_rsp_wait;
  logic                                r_rsp_err;
  logic [NUM_CH-1:0]                   r_overrun;

  // Round-robin pick: scanning downward lets the candidate closest to r_ptr win.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_ch  = '0;
    w_grant_oh  = '0;
    w_cand      = '0;
    if (r_state == S_IDLE) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        w_cand = (int'(r_ptr) + k >= NUM_CH) ? CH_W'(int'(r_ptr) + k - NUM_CH)
                                             : CH_W'(int'(r_ptr) + k);
        w_grant_vld = w_grant_vld | r_pending[w_cand];
        w_grant_ch  = r_pending[w_cand] ? w_cand : w_grant_ch;
      end
    end else begin
      w_grant_vld = 1'b0;
    end
    w_grant_oh[w_grant_ch] = w_grant_vld;
  end

  assign w_timeout = (r_to_cnt == TO_W'(READY_TIMEOUT - 1));

  // Next-state logic of the handshake sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    w_state_next = w_grant_vld ? S_EVENT : S_IDLE;
      S_EVENT:   w_state_next = S_GAP;
      S_GAP:     w_state_next = (r_gap_cnt == GAP_W'(CONFIRM_DELAY - 1)) ? S_CONFIRM : S_GAP;
      S_CONFIRM: w_state_next = S_WAITR;
      S_WAITR:   w_state_next = (bus.ts_ready || w_timeout) ? S_DONE : S_WAITR;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // State, pointer, gap and timeout counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gap_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_next;
      if (w_grant_vld) begin
        r_ptr <= (w_grant_ch == CH_W'(NUM_CH - 1)) ? '0 : w_grant_ch + 1'b1;
      end
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
      r_to_cnt  <= (r_state == S_WAITR) ? r_to_cnt + 1'b1 : '0;
    end
  end

  // Request latching; a repeat while still pending is dropped and flagged as overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_overrun <= '0;
      for (int i = 0; i < NUM_CH; i++) r_wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_overrun[i] <= bus.req[i] & r_pending[i] & ~w_grant_oh[i];
        if (bus.req[i] && !(r_pending[i] && !w_grant_oh[i])) begin
          r_pending[i]  <= 1'b1;
          r_wait_cnt[i] <= '0;
        end else if (w_grant_oh[i]) begin
          r_pending[i]  <= 1'b0;
        end else if (r_pending[i] && (r_wait_cnt[i] != '1)) begin
          r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Grant snapshot and response fields; data holds until the next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_ch   <= '0;
      r_grant_wait <= '0;
      r_rsp_ch     <= '0;
      r_rsp_utc    <= '0;
      r_rsp_clk    <= '0;
      r_rsp_drift  <= '0;
      r_rsp_wait   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_grant_vld) begin
        r_grant_ch   <= w_grant_ch;
        r_grant_wait <= r_wait_cnt[w_grant_ch];
      end
      if ((r_state == S_WAITR) && (w_state_next == S_DONE)) begin
        r_rsp_ch    <= r_grant_ch;
        r_rsp_wait  <= r_grant_wait;
        r_rsp_err   <= ~bus.ts_ready;
        r_rsp_utc   <= bus.ts_ready ? bus.ts_utc   : '0;
        r_rsp_clk   <= bus.ts_ready ? bus.ts_clk   : '0;
        r_rsp_drift <= bus.ts_ready ? bus.ts_drift : '0;
      end
    end
  end

  // Strobes decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts_event   <= 1'b0;
      r_ts_confirm <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_ts_event   <= (w_state_next == S_EVENT);
      r_ts_confirm <= (w_state_next == S_CONFIRM);
      r_rsp_valid  <= (w_state_next == S_DONE);
      r_busy       <= (w_state_next != S_IDLE);
    end
  end

  assign bus.ts_event   = r_ts_event;
  assign bus.ts_confirm = r_ts_confirm;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_ch     = r_rsp_ch;
  assign bus.rsp_utc    = r_rsp_utc;
  assign bus.rsp_clk    = r_rsp_clk;
  assign bus.rsp_drift  = r_rsp_drift;
  assign bus.rsp_wait   = r_rsp_wait;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_ts_capture_arbiter.sv
// Bench for ts_capture_arbiter: table of request scenarios with a response scoreboard,
// a behavioural timestamp unit, and hand-written overrun and mid-handshake reset sequences.
`timescale 1ns/1ps
module tb_ts_capture_arbiter;
  localparam int NUM_CH  = 4;
  localparam int UTC_W   = 6;
  localparam int CNT_W   = 26;
  localparam int DRIFT_W = 13;
  localparam int WAIT_W  = 8;
  localparam int CD      = 2;
  localparam int RT      = 15;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  ts_capture_arbiter_if #(.NUM_CH(NUM_CH), .UTC_SECONDS_WIDTH(UTC_W),
    .COUNT_LAST_SECOND_WIDTH(CNT_W), .DRIFT_COUNT_WIDTH(DRIFT_W), .WAIT_WIDTH(WAIT_W)) bus ();

  ts_capture_arbiter #(.NUM_CH(NUM_CH), .UTC_SECONDS_WIDTH(UTC_W),
    .COUNT_LAST_SECOND_WIDTH(CNT_W), .DRIFT_COUNT_WIDTH(DRIFT_W), .WAIT_WIDTH(WAIT_W),
    .CONFIRM_DELAY(CD), .READY_TIMEOUT(RT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  typedef struct {
    logic [1:0]                ch;
    logic [UTC_W-1:0]          utc;
    logic [CNT_W-1:0]          clkv;
    logic signed [DRIFT_W-1:0] drift;
    logic [WAIT_W-1:0]         wt;
    logic                      err;
    int                        cyc;
  } exp_t;

  typedef struct {
    logic [NUM_CH-1:0]         mask;
    int                        lat_first;
    int                        lat_rest;
    logic [UTC_W-1:0]          utc;
    logic [CNT_W-1:0]          clkv;
    logic signed [DRIFT_W-1:0] drift;
    int                        n;
    logic [3:0][1:0]           order;
  } vec_t;

  exp_t sb[$];

  // Timestamp-unit model: ready comes lat cycles after confirm (lat 0 = never).
  int                        lat_first = 1;
  int                        lat_rest  = 1;
  int                        unit_idx  = 0;
  int                        scen_base = 0;
  logic [UTC_W-1:0]          base_utc;
  logic [CNT_W-1:0]          base_clk;
  logic signed [DRIFT_W-1:0] base_drift;

  int ev_count = 0;
  int conf_count = 0;
  int last_ev = 0;
  int last_conf = 0;
  int ovr_cnt [NUM_CH];

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int period(input int lat);
    return 4 + CD + ((lat == 0) ? RT : lat);
  endfunction

  initial begin : unit_model
    int cnt;
    int k_now;
    int lat_now;
    cnt = 0;
    k_now = 0;
    bus.ts_ready = 1'b0;
    bus.ts_utc   = '0;
    bus.ts_clk   = '0;
    bus.ts_drift = '0;
    forever begin
      @(negedge clk);
      bus.ts_ready = 1'b0;
      bus.ts_utc   = UTC_W'($urandom);
      bus.ts_clk   = CNT_W'($urandom);
      bus.ts_drift = DRIFT_W'($urandom);
      if (bus.ts_confirm) begin
        k_now    = unit_idx - scen_base;
        lat_now  = (k_now == 0) ? lat_first : lat_rest;
        unit_idx = unit_idx + 1;
        cnt      = lat_now;
      end else if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          bus.ts_ready = 1'b1;
          bus.ts_utc   = base_utc + UTC_W'(k_now);
          bus.ts_clk   = base_clk + CNT_W'(k_now);
          bus.ts_drift = base_drift - DRIFT_W'(k_now);
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    for (int i = 0; i < NUM_CH; i++) ovr_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (bus.ts_event) begin
        ev_count = ev_count + 1;
        last_ev  = cyc;
      end
      if (bus.ts_confirm) begin
        conf_count = conf_count + 1;
        last_conf  = cyc;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.overrun[i]) ovr_cnt[i] = ovr_cnt[i] + 1;
      end
      if (bus.rsp_valid) begin
        chk("rsp_expected", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_cycle", cyc, e.cyc);
          chk("rsp_ch", bus.rsp_ch, e.ch);
          chk("rsp_utc", bus.rsp_utc, e.utc);
          chk("rsp_clk", bus.rsp_clk, e.clkv);
          chk("rsp_drift", longint'(bus.rsp_drift), longint'(e.drift));
          chk("rsp_wait", bus.rsp_wait, e.wt);
          chk("rsp_err", bus.rsp_err, e.err);
        end
      end
    end
  end

  task automatic push_exp(input int ch, input int k, input int lat, input int wt, input int rcyc);
    exp_t e;
    e.ch    = 2'(ch);
    e.err   = (lat == 0);
    e.utc   = (lat == 0) ? '0 : base_utc + UTC_W'(k);
    e.clkv  = (lat == 0) ? '0 : base_clk + CNT_W'(k);
    e.drift = (lat == 0) ? '0 : base_drift - DRIFT_W'(k);
    e.wt    = WAIT_W'(wt);
    e.cyc   = rcyc;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("drain", sb.size(), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    chk("idle_busy", bus.busy, 0);
  endtask

  task automatic set_unit(input int lf, input int lr, input logic [UTC_W-1:0] u,
                          input logic [CNT_W-1:0] c, input logic signed [DRIFT_W-1:0] d);
    scen_base  = unit_idx;
    lat_first  = lf;
    lat_rest   = lr;
    base_utc   = u;
    base_clk   = c;
    base_drift = d;
  endtask

  // One-cycle request burst; the k-th served channel waits for all earlier services.
  task automatic run_vec(input vec_t v, output int t_req);
    int acc;
    int lat;
    set_unit(v.lat_first, v.lat_rest, v.utc, v.clkv, v.drift);
    @(posedge clk);
    #1;
    bus.req = v.mask;
    t_req   = cyc;
    acc     = 0;
    for (int k = 0; k < v.n; k++) begin
      lat = (k == 0) ? v.lat_first : v.lat_rest;
      push_exp(int'(v.order[k]), k, lat, acc, t_req + acc + period(lat));
      acc = acc + period(lat);
    end
    @(posedge clk);
    #1;
    bus.req = '0;
    wait_drain(300);
  endtask

  task automatic run_single();
    vec_t v;
    int   t_req;
    int   ev0;
    v = '{mask: 4'b0100, lat_first: 1, lat_rest: 1, utc: 6'd17, clkv: 26'd1234567,
          drift: -13'sd3, n: 1, order: {2'd0, 2'd0, 2'd0, 2'd2}};
    ev0 = ev_count;
    run_vec(v, t_req);
    chk("single_event_cycle", last_ev - t_req, 2);
    chk("single_confirm_cycle", last_conf - t_req, 5);
    chk("single_event_pulses", ev_count - ev0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vecs [4];
    vec_t vpost;
    int   t_req;
    int   ovr_prev [NUM_CH];
    int   others;

    vecs[0] = '{mask: 4'b1111, lat_first: 1, lat_rest: 1, utc: 6'd10, clkv: 26'd5000,
                drift: 13'sd20, n: 4, order: {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{mask: 4'b0010, lat_first: 3, lat_rest: 3, utc: 6'd33, clkv: 26'd40000000,
                drift: -13'sd100, n: 1, order: {2'd0, 2'd0, 2'd0, 2'd1}};
    vecs[2] = '{mask: 4'b1001, lat_first: 2, lat_rest: 2, utc: 6'd59, clkv: 26'd777,
                drift: 13'sd4000, n: 2, order: {2'd0, 2'd0, 2'd0, 2'd3}};
    vecs[3] = '{mask: 4'b0101, lat_first: 0, lat_rest: 1, utc: 6'd1, clkv: 26'd99,
                drift: -13'sd4095, n: 2, order: {2'd0, 2'd0, 2'd0, 2'd2}};
    vpost   = '{mask: 4'b0101, lat_first: 1, lat_rest: 1, utc: 6'd40, clkv: 26'd12345,
                drift: 13'sd7, n: 2, order: {2'd0, 2'd0, 2'd2, 2'd0}};

    rst     = 1'b1;
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk("reset_ts_event", bus.ts_event, 0);
    chk("reset_ts_confirm", bus.ts_confirm, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_ch", bus.rsp_ch, 0);
    chk("reset_rsp_utc", bus.rsp_utc, 0);
    chk("reset_rsp_clk", bus.rsp_clk, 0);
    chk("reset_rsp_drift", bus.rsp_drift, 0);
    chk("reset_rsp_wait", bus.rsp_wait, 0);
    chk("reset_rsp_err", bus.rsp_err, 0);
    chk("reset_overrun", bus.overrun, 0);
    chk("reset_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_reset_busy", bus.busy, 0);

    // Contention from ptr 0, single ch1, fairness (ch3 before ch0), timeout then normal.
    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], t_req);
    end

    // Second req[1] while ch1 waits behind ch0 is dropped; wait counts from the first req.
    for (int i = 0; i < NUM_CH; i++) ovr_prev[i] = ovr_cnt[i];
    set_unit(1, 1, 6'd5, 26'd100, 13'sd7);
    @(posedge clk);
    #1;
    bus.req = 4'b0001;
    t_req   = cyc;
    push_exp(0, 0, 1, 0, t_req + period(1));
    push_exp(1, 1, 1, period(1) - 1, t_req + 2 * period(1));
    @(posedge clk);
    #1;
    bus.req = 4'b0010;
    @(posedge clk);
    #1;
    bus.req = '0;
    @(posedge clk);
    #1;
    bus.req = 4'b0010;
    @(posedge clk);
    #1;
    bus.req = '0;
    wait_drain(300);
    chk("overrun_ch1_pulses", ovr_cnt[1] - ovr_prev[1], 1);
    others = (ovr_cnt[0] - ovr_prev[0]) + (ovr_cnt[2] - ovr_prev[2]) + (ovr_cnt[3] - ovr_prev[3]);
    chk("overrun_other_pulses", others, 0);

    run_single();

    // Reset while waiting for ready, with ch3 still pending: nothing may be answered.
    set_unit(0, 0, 6'd0, 26'd0, 13'sd0);
    @(posedge clk);
    #1;
    bus.req = 4'b0010;
    @(posedge clk);
    #1;
    bus.req = 4'b1000;
    @(posedge clk);
    #1;
    bus.req = '0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_ts_confirm", bus.ts_confirm, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_midrst_busy", bus.busy, 0);

    // Pointer restarts at 0 after reset, then the single-request timing holds again.
    run_vec(vpost, t_req);
    run_single();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
